// File: rtl/delay_search_ctrl.sv
// Receiver alignment controller: sweeps symbol/sample delay candidates and keeps the one with minimum accumulated squared error.
// Optional early exit on a low-error candidate is enabled by defining DELAY_SEARCH_EARLY_EXIT_EN.
module delay_search_ctrl #(
  parameter logic [7:0]  SYM_MIN        = 8'd50,
  parameter logic [7:0]  SYM_MAX        = 8'd54,
  parameter int unsigned SETTLE_PERIODS = 1,
  parameter int unsigned ERR_W          = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sym_clk_en_i,
  input  logic             start_i,
  input  logic             hold_i,
  input  logic [ERR_W-1:0] acc_sq_err_i,
`ifdef DELAY_SEARCH_EARLY_EXIT_EN
  input  logic [ERR_W-1:0] early_thresh_i,
`endif
  output logic [1:0]       sam_delay_o,
  output logic [7:0]       sym_delay_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ERR_W-1:0] best_err_o,
  output logic [1:0]       best_sam_o,
  output logic [7:0]       best_sym_o
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_STEP, S_FINISH} state_e;

  localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_PERIODS);

  state_e           state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic [1:0]       sam_q, sam_d;
  logic [7:0]       sym_q, sym_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] best_err_q, best_err_d;
  logic [1:0]       best_sam_q, best_sam_d;
  logic [7:0]       best_sym_q, best_sym_d;

  logic better, last_cand, early_hit;

  assign better    = acc_sq_err_i < best_err_q;
  assign last_cand = (sym_q == SYM_MAX) && (sam_q == 2'd3);
`ifdef DELAY_SEARCH_EARLY_EXIT_EN
  // Unsigned compare: a zero threshold can never be undercut.
  assign early_hit = acc_sq_err_i < early_thresh_i;
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      sam_q      <= '0;
      sym_q      <= SYM_MIN;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      best_err_q <= '1;
      best_sam_q <= '0;
      best_sym_q <= SYM_MIN;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      sam_q      <= sam_d;
      sym_q      <= sym_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      best_err_q <= best_err_d;
      best_sam_q <= best_sam_d;
      best_sym_q <= best_sym_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sym_clk_en_i) begin
      unique case (state_q)
        S_IDLE:    if (start_i) state_d = S_SETTLE;
        // Zero counter, or the period end that exhausts it, moves on immediately.
        S_SETTLE:  if ((settle_q == 2'd0) || (hold_i && (settle_q == 2'd1))) state_d = S_MEASURE;
        S_MEASURE: if (hold_i) state_d = early_hit ? S_FINISH : S_STEP;
        S_STEP:    state_d = last_cand ? S_FINISH : S_SETTLE;
        S_FINISH:  state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    settle_d   = settle_q;
    sam_d      = sam_q;
    sym_d      = sym_q;
    busy_d     = busy_q;
    done_d     = done_q;
    best_err_d = best_err_q;
    best_sam_d = best_sam_q;
    best_sym_d = best_sym_q;
    if (sym_clk_en_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            best_err_d = '1;
            sym_d      = SYM_MIN;
            sam_d      = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            settle_d   = SETTLE_INIT;
          end
        end
        S_SETTLE: begin
          if (hold_i && (settle_q != 2'd0)) settle_d = settle_q - 2'd1;
        end
        S_MEASURE: begin
          if (hold_i && better) begin
            best_err_d = acc_sq_err_i;
            best_sam_d = sam_q;
            best_sym_d = sym_q;
          end
        end
        S_STEP: begin
          if (!last_cand) begin
            if (sam_q != 2'd3) begin
              sam_d = sam_q + 2'd1;
            end else begin
              sam_d = '0;
              sym_d = sym_q + 8'd1;
            end
            settle_d = SETTLE_INIT;
          end
        end
        S_FINISH: begin
          sam_d  = best_sam_q;
          sym_d  = best_sym_q;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sam_delay_o = sam_q;
  assign sym_delay_o = sym_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign best_err_o  = best_err_q;
  assign best_sam_o  = best_sam_q;
  assign best_sym_o  = best_sym_q;

endmodule

// File: doc/delay_search_ctrl.md
Name: delay_search_ctrl

Overview:
- Receiver alignment controller. It sweeps the `config_sym_delay` and `config_sam_delay` settings through a window and measures `err_sq_gen`'s accumulated squared error over one LFSR period per candidate.
- It latches the candidate with the minimum error and drives that setting onto the delay blocks.
- It sits beside the RX chain and replaces the hard-coded delay constants (sym 52, sam 0).

Parameters:
- SYM_MIN, 8'd50, first symbol delay tried.
- SYM_MAX, 8'd54, last symbol delay tried (inclusive, SYM_MAX >= SYM_MIN).
- SETTLE_PERIODS, 1, measurement periods discarded after each delay change (pipeline flush). Range 0..3.
- ERR_W, 18, width of the error input.

Ports:
- clk  in  1  system clock (sys_clk).
- reset  in  1  asynchronous, active-low reset.
- sym_clk_en  in  1  symbol-rate enable. All state advances only when high.
- start  in  1  level/pulse request to begin a sweep. Sampled on sym_clk_en.
- hold  in  1  end-of-LFSR-period pulse (cycle_out_periodic). acc_sq_err is valid when hold && sym_clk_en.
- acc_sq_err  in  ERR_W  accumulated squared error, treated as unsigned.
- sam_delay  out  2  sample-delay setting to config_sam_delay.
- sym_delay  out  8  symbol-delay setting to config_sym_delay / config_data_delay.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next accepted start.
- best_err  out  ERR_W  minimum error found.
- best_sam  out  2  sam_delay of best candidate.
- best_sym  out  8  sym_delay of best candidate.

Behaviour:
- Reset (reset low, asynchronous) values:
  - state = IDLE, busy = 0, done = 0.
  - sam_delay = 0, sym_delay = SYM_MIN.
  - best_err = all ones, best_sam = 0, best_sym = SYM_MIN.
- Reset asserted mid-sweep aborts immediately to these values.
- "tick" means sym_clk_en = 1. "period end" means tick && hold.
- IDLE:
  - On tick && start: clear best_err to all ones; set sym_delay = SYM_MIN, sam_delay = 0, busy = 1, done = 0; go to SETTLE with settle counter = SETTLE_PERIODS.
- SETTLE:
  - Each period end decrements the counter.
  - If the counter is 0 on entry, or reaches 0, go to MEASURE without waiting for a further period end.
  - With SETTLE_PERIODS = 0, MEASURE is entered on the next tick.
- MEASURE:
  - On period end, capture acc_sq_err.
  - If acc_sq_err < best_err (strict; ties keep the earlier candidate), load best_err, best_sam = sam_delay, best_sym = sym_delay.
  - Then go to STEP on the next tick.
- STEP (one tick):
  - If sam_delay < 3: sam_delay + 1.
  - Else sam_delay = 0 and sym_delay + 1.
  - If the candidate just measured was (SYM_MAX, 3), go to FINISH. Otherwise reload the settle counter and go to SETTLE.
- FINISH (one tick):
  - sam_delay = best_sam, sym_delay = best_sym, busy = 0, done = 1.
  - Go to IDLE.
- start while busy is ignored. start in IDLE with done = 1 restarts the sweep and clears done.
- hold arriving in STEP/FINISH/IDLE is ignored.
- A hold coincident with the tick that entered SETTLE counts toward settling. A change takes effect on the tick after the registered write.
- Sweep length = 4*(SYM_MAX-SYM_MIN+1) candidates, each consuming SETTLE_PERIODS+1 period ends.
- Delay outputs are registered; the comparator is combinational on the registered best_err.
- sym_delay never exceeds SYM_MAX; no wrap-around.

Optional Feature:
- Macro: DELAY_SEARCH_EARLY_EXIT_EN.
- When defined:
  - Adds input early_thresh [ERR_W-1:0].
  - In MEASURE, if the captured acc_sq_err < early_thresh, the candidate is recorded as best (it is necessarily below best_err unless best_err is lower) and the controller jumps straight to FINISH, skipping the remaining candidates.
  - early_thresh = 0 never triggers.
- When undefined: no port, and the full sweep always runs.

Test Plan:
- Reset then start, SETTLE_PERIODS = 1; error model returns 1000 except 40 at (sym 52, sam 0).
  - Expect 20 candidates over 40 period ends.
  - On completion: done = 1, busy = 0, best_sym = 52, best_sam = 0, best_err = 40, sym_delay = 52, sam_delay = 0.
- Tie case: errors 500 at (51,2) and (53,1), 900 elsewhere → best = (51,2).
- Drive reset low during candidate (53,0).
  - Expect immediate busy = 0, sym_delay = 50, sam_delay = 0, best_err = 0x3FFFF.
  - A new start runs a full sweep.
- Pulse start at candidate 5 → ignored; sweep order and count unchanged.
- SETTLE_PERIODS = 0: each candidate is measured on the first period end; 20 period ends total; the first acc_sq_err after each change is used.
- DELAY_SEARCH_EARLY_EXIT_EN, early_thresh = 100; error 60 at (51,1).
  - Expect FINISH right after that measure: done = 1, best = (51,1,60), 6 candidates measured.
